// File: rtl/mac_addr_table_axil_pkg.sv
// Shared constants and types for the MAC address table register block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_addr_pkg;

  typedef logic [47:0] mac_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_DECERR = 2'b11
  } resp_t;

  // Global registers
  localparam logic [31:0] REG_VERSION  = 32'h00;
  localparam logic [31:0] REG_CH_COUNT = 32'h04;

  // Per-channel window: base + stride * channel
  localparam logic [31:0] CH_BASE   = 32'h10;
  localparam logic [31:0] CH_STRIDE = 32'h10;

  // Offsets inside one channel window
  localparam logic [3:0] REG_MAC_LO = 4'h0;
  localparam logic [3:0] REG_MAC_HI = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;
  localparam logic [3:0] REG_STATUS = 4'hC;

endpackage

// File: rtl/mac_ch_regs.sv
// One channel: shadow/active MAC, CTRL/STATUS, commit validation, req/ack handshake.
// Latency: register writes and commits take effect on the write strobe edge; read data is combinational.
// Backpressure: none; a commit while a request is outstanding is refused and flagged as overrun.
module mac_ch_regs
  import mac_addr_pkg::*;
#(
  parameter mac_t RESET_MAC = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_vld,
  input  logic [3:0]  i_wr_off,
  input  logic [31:0] i_wr_dat,
  input  logic [3:0]  i_wr_strb,
  input  logic [3:0]  i_rd_off,
  output logic [31:0] o_rd_dat,
  output mac_t        o_mac,
  output logic        o_en,
  output logic        o_req,
  input  logic        i_ack
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [0:0] r_state;
  mac_t       r_shadow;
  mac_t       r_active;
  logic       r_en;
  logic       r_ovr;
  logic       r_inv;

  logic w_pending;
  logic w_bad;
  logic w_commit;
  logic w_set_ovr;
  logic w_set_inv;
  logic w_accept;
  logic w_sts_wr;
  logic w_clr_ovr;
  logic w_clr_inv;
  logic w_ctrl_wr;

  // The commit bit lives in byte 0, so it only counts when that lane is strobed.
  assign w_ctrl_wr = i_wr_vld && (i_wr_off == REG_CTRL) && i_wr_strb[0];
  assign w_commit  = w_ctrl_wr && i_wr_dat[1];
  assign w_pending = (r_state == ST_REQ);
  // Zero or group (multicast) addresses are never legal source MACs.
  assign w_bad     = (r_shadow == '0) || r_shadow[40];
  assign w_set_ovr = w_commit && w_pending;
  assign w_set_inv = w_commit && !w_pending && w_bad;
  assign w_accept  = w_commit && !w_pending && !w_bad;
  assign w_sts_wr  = i_wr_vld && (i_wr_off == REG_STATUS) && i_wr_strb[0];
  assign w_clr_ovr = w_sts_wr && i_wr_dat[1];
  assign w_clr_inv = w_sts_wr && i_wr_dat[2];

  // Shadow MAC: byte-lane writes to MAC_LO / MAC_HI
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= RESET_MAC;
    end else if (i_wr_vld) begin
      if (i_wr_off == REG_MAC_LO) begin
        for (int b = 0; b < 4; b++) begin
          if (i_wr_strb[b]) r_shadow[8*b +: 8] <= i_wr_dat[8*b +: 8];
        end
      end else if (i_wr_off == REG_MAC_HI) begin
        for (int b = 0; b < 2; b++) begin
          if (i_wr_strb[b]) r_shadow[32 + 8*b +: 8] <= i_wr_dat[8*b +: 8];
        end
      end
    end
  end

  // Handshake FSM and active MAC: load on accepted commit, release on ack
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_active <= RESET_MAC;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_active <= r_shadow;
            r_state  <= ST_REQ;
          end
        end
        default: begin
          if (i_ack) r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Enable bit and sticky status flags; a set event beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en  <= 1'b0;
      r_ovr <= 1'b0;
      r_inv <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_en <= i_wr_dat[0];
      r_ovr <= w_set_ovr | (r_ovr & ~w_clr_ovr);
      r_inv <= w_set_inv | (r_inv & ~w_clr_inv);
    end
  end

  // Register read mux for this channel's window
  always_comb begin
    o_rd_dat = '0;
    case (i_rd_off)
      REG_MAC_LO: o_rd_dat = r_shadow[31:0];
      REG_MAC_HI: o_rd_dat = {16'h0000, r_shadow[47:32]};
      REG_CTRL:   o_rd_dat = {31'd0, r_en};
      REG_STATUS: o_rd_dat = {29'd0, r_inv, r_ovr, w_pending};
      default:    o_rd_dat = '0;
    endcase
  end

  assign o_mac = r_active;
  assign o_en  = r_en;
  assign o_req = w_pending;

endmodule

// File: rtl/mac_addr_table_axil.sv
// AXI4-Lite slave exposing per-channel source MAC registers with atomic commit.
// Latency: READY one cycle after both valids, BVALID/RVALID one cycle after the handshake.
// Backpressure: no new write/read is accepted while BVALID/RVALID waits for BREADY/RREADY.
module mac_addr_table_axil
  import mac_addr_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          ADDR_W      = 8,
  parameter logic [47:0] DEFAULT_MAC = 48'h000A35000000,
  parameter logic [31:0] VERSION     = 32'h0002_0000
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic [48*NUM_CH-1:0]  mac_out,
  output logic [NUM_CH-1:0]     mac_en,
  output logic [NUM_CH-1:0]     mac_upd_req,
  input  logic [NUM_CH-1:0]     mac_upd_ack
);

  logic        r_wr_rdy;
  logic        r_bvalid;
  resp_t       r_bresp;
  logic        r_arready;
  logic        r_rvalid;
  resp_t       r_rresp;
  logic [31:0] r_rdata;

  logic [31:0] w_awaddr;
  logic [31:0] w_araddr;
  logic [31:0] w_ch_end;
  logic        w_aw_ch_hit;
  logic        w_ar_ch_hit;
  logic [3:0]  w_aw_ch;
  logic [3:0]  w_ar_ch;
  logic        w_aw_ok;
  logic        w_wr_hs;
  logic        w_rd_hs;
  logic [31:0] w_rd_dat;
  logic        w_rd_err;
  logic [31:0] w_ch_rdat [NUM_CH];
  logic        w_unused;

  // Protection attributes carry no meaning for this block.
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // Word-aligned decode; byte offset bits are ignored.
  assign w_awaddr    = 32'(S_AXI_AWADDR) & ~32'h3;
  assign w_araddr    = 32'(S_AXI_ARADDR) & ~32'h3;
  assign w_ch_end    = CH_BASE + CH_STRIDE * 32'(NUM_CH);
  assign w_aw_ch_hit = (w_awaddr >= CH_BASE) && (w_awaddr < w_ch_end);
  assign w_ar_ch_hit = (w_araddr >= CH_BASE) && (w_araddr < w_ch_end);
  // Channel windows are 16 bytes wide.
  assign w_aw_ch     = 4'((w_awaddr - CH_BASE) >> 4);
  assign w_ar_ch     = 4'((w_araddr - CH_BASE) >> 4);
  assign w_aw_ok     = (w_awaddr == REG_VERSION) || (w_awaddr == REG_CH_COUNT) || w_aw_ch_hit;

  assign w_wr_hs = r_wr_rdy & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd_hs = r_arready & S_AXI_ARVALID;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic w_wr_sel;
    assign w_wr_sel = w_wr_hs && w_aw_ch_hit && (w_aw_ch == 4'(c));

    mac_ch_regs #(
      .RESET_MAC (DEFAULT_MAC + 48'(c))
    ) u_ch (
      .clk       (ACLK),
      .rst       (ARESET),
      .i_wr_vld  (w_wr_sel),
      .i_wr_off  (w_awaddr[3:0]),
      .i_wr_dat  (S_AXI_WDATA),
      .i_wr_strb (S_AXI_WSTRB),
      .i_rd_off  (w_araddr[3:0]),
      .o_rd_dat  (w_ch_rdat[c]),
      .o_mac     (mac_out[48*c +: 48]),
      .o_en      (mac_en[c]),
      .o_req     (mac_upd_req[c]),
      .i_ack     (mac_upd_ack[c])
    );
  end

  // Read data mux across global and channel registers
  always_comb begin
    w_rd_dat = '0;
    w_rd_err = 1'b0;
    if (w_araddr == REG_VERSION) begin
      w_rd_dat = VERSION;
    end else if (w_araddr == REG_CH_COUNT) begin
      w_rd_dat = 32'(NUM_CH);
    end else if (w_ar_ch_hit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_ar_ch == 4'(c)) w_rd_dat = w_ch_rdat[c];
      end
    end else begin
      w_rd_err = 1'b1;
    end
  end

  // Write channel: one-cycle AW/W ready pulse, then hold B until accepted
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wr_rdy <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else begin
      r_wr_rdy <= S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid & ~r_wr_rdy;
      if (w_wr_hs) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_aw_ok ? RESP_OKAY : RESP_DECERR;
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read channel: one-cycle AR ready pulse, then hold R until accepted
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_arready <= S_AXI_ARVALID & ~r_rvalid & ~r_arready;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_dat;
        r_rresp  <= w_rd_err ? RESP_DECERR : RESP_OKAY;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = r_wr_rdy;
  assign S_AXI_WREADY  = r_wr_rdy;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;

endmodule

// File: tb/tb_mac_addr_table_axil.sv
// Self-checking bench for mac_addr_table_axil against an address-map level model.
// Latency: n/a.
// Backpressure: bus tasks bound every wait on the DUT.
module tb_mac_addr_table_axil;

  localparam int          N    = 4;
  localparam logic [47:0] DMAC = 48'h000A35000000;
  localparam logic [31:0] VER  = 32'h0002_0000;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [7:0]    S_AXI_AWADDR;
  logic [2:0]    S_AXI_AWPROT;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [7:0]    S_AXI_ARADDR;
  logic [2:0]    S_AXI_ARPROT;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;
  logic [48*N-1:0] mac_out;
  logic [N-1:0]  mac_en;
  logic [N-1:0]  mac_upd_req;
  logic [N-1:0]  mac_upd_ack;

  mac_addr_table_axil #(
    .NUM_CH(N), .ADDR_W(8), .DEFAULT_MAC(DMAC), .VERSION(VER)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .mac_out(mac_out), .mac_en(mac_en), .mac_upd_req(mac_upd_req), .mac_upd_ack(mac_upd_ack)
  );

  always #5 ACLK = ~ACLK;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the programmer-visible state of every channel
  logic [47:0] m_shadow [N];
  logic [47:0] m_active [N];
  bit          m_en     [N];
  bit          m_pend   [N];
  bit          m_ovr    [N];
  bit          m_inv    [N];

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_shadow[c] = DMAC + 48'(c);
      m_active[c] = DMAC + 48'(c);
      m_en[c] = 0; m_pend[c] = 0; m_ovr[c] = 0; m_inv[c] = 0;
    end
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
    int a, c, off;
    logic [31:0] m;
    a = int'(addr) & 'hFC;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    resp = 2'b00;
    if (a == 0 || a == 4) return;
    if (a < 16 || a >= 16 + 16 * N) begin resp = 2'b11; return; end
    c = (a - 16) / 16;
    off = a % 16;
    case (off)
      0: m_shadow[c][31:0] = (m_shadow[c][31:0] & ~m) | (d & m);
      4: m_shadow[c][47:32] = (m_shadow[c][47:32] & ~m[15:0]) | (d[15:0] & m[15:0]);
      8: if (s[0]) begin
           m_en[c] = d[0];
           if (d[1]) begin
             if (m_pend[c]) m_ovr[c] = 1;
             else if (m_shadow[c] == 48'd0 || m_shadow[c][40]) m_inv[c] = 1;
             else begin m_active[c] = m_shadow[c]; m_pend[c] = 1; end
           end
         end
      default: if (s[0]) begin
           if (d[1]) m_ovr[c] = 0;
           if (d[2]) m_inv[c] = 0;
         end
    endcase
  endtask

  task automatic model_read(input logic [7:0] addr, output logic [31:0] d, output logic [1:0] resp);
    int a, c, off;
    a = int'(addr) & 'hFC;
    d = 0; resp = 2'b00;
    if (a == 0) d = VER;
    else if (a == 4) d = N;
    else if (a < 16 || a >= 16 + 16 * N) resp = 2'b11;
    else begin
      c = (a - 16) / 16;
      off = a % 16;
      case (off)
        0: d = m_shadow[c][31:0];
        4: d = {16'd0, m_shadow[c][47:32]};
        8: d = {31'd0, m_en[c]};
        default: d = {29'd0, m_inv[c], m_ovr[c], m_pend[c]};
      endcase
    end
  endtask

  function automatic logic [48*N-1:0] exp_mac();
    logic [48*N-1:0] v;
    for (int c = 0; c < N; c++) v[48*c +: 48] = m_active[c];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_en();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = m_en[c];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_req();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = m_pend[c];
    return v;
  endfunction

  // Bus tasks: start and end #1 after a rising edge
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input bit hold_b, output logic [1:0] resp);
    int n;
    resp = 2'bxx;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWPROT = 3'($urandom_range(0, 7));
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 0;
    n = 0;
    while (!S_AXI_AWREADY && n < 50) begin @(posedge ACLK); #1; n++; end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL aw_timeout: awready=%0b required 1", S_AXI_AWREADY);
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
      return;
    end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin @(posedge ACLK); #1; n++; end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL b_timeout: bvalid=%0b required 1", S_AXI_BVALID);
      return;
    end
    resp = S_AXI_BRESP;
    if (!hold_b) begin
      S_AXI_BREADY = 1; @(posedge ACLK); #1; S_AXI_BREADY = 0;
    end
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    data = 'x; resp = 2'bxx;
    S_AXI_ARADDR = addr; S_AXI_ARPROT = 3'($urandom_range(0, 7));
    S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(posedge ACLK); #1; n++; end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL ar_timeout: arready=%0b required 1", S_AXI_ARREADY);
      S_AXI_ARVALID = 0;
      return;
    end
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 0;
    n = 0;
    while (!S_AXI_RVALID && n < 50) begin @(posedge ACLK); #1; n++; end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL r_timeout: rvalid=%0b required 1", S_AXI_RVALID);
      return;
    end
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    S_AXI_RREADY = 1; @(posedge ACLK); #1; S_AXI_RREADY = 0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    output logic [1:0] r, output logic [1:0] er);
    axi_write(addr, data, strb, 1'b0, r);
    model_write(addr, data, strb, er);
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] d, output logic [1:0] r,
                    output logic [31:0] ed, output logic [1:0] er);
    model_read(addr, ed, er);
    axi_read(addr, d, r);
  endtask

  task automatic pulse_ack(input int c);
    mac_upd_ack[c] = 1'b1;
    @(posedge ACLK); #1;
    mac_upd_ack[c] = 1'b0;
    if (m_pend[c]) m_pend[c] = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d, ed; logic [1:0] r, er;
    ARESET = 1;
    repeat (3) @(posedge ACLK);
    #1;
    model_reset();
    vectors++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: got %b required 00000",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
    end
    vectors++;
    if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_resp: bresp=%b rresp=%b rdata=%h required 0", S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA);
    end
    vectors++;
    if (mac_out !== exp_mac() || mac_en !== '0 || mac_upd_req !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: mac=%h en=%b req=%b required mac=%h en=0 req=0",
               mac_out, mac_en, mac_upd_req, exp_mac());
    end
    ARESET = 0;
    @(posedge ACLK); #1;
    rd(8'h00, d, r, ed, er);
    vectors++;
    if (d !== 32'h0002_0000 || r !== 2'b00) begin miscompares++; $display("FAIL rd_version: got %h/%b required 00020000/00", d, r); end
    rd(8'h04, d, r, ed, er);
    vectors++;
    if (d !== 32'd4) begin miscompares++; $display("FAIL rd_ch_count: got %h required 4", d); end
    rd(8'h10, d, r, ed, er);
    vectors++;
    if (d !== 32'h3500_0000) begin miscompares++; $display("FAIL rd_ch0_lo: got %h required 35000000", d); end
    rd(8'h14, d, r, ed, er);
    vectors++;
    if (d !== 32'h0000_000A) begin miscompares++; $display("FAIL rd_ch0_hi: got %h required 0000000a", d); end
    vectors++;
    if (mac_out[48 +: 48] !== 48'h000A35000001) begin
      miscompares++; $display("FAIL reset_mac1: got %h required 000a35000001", mac_out[48 +: 48]);
    end
  endtask

  task automatic test_commit();
    logic [31:0] d, ed; logic [1:0] r, er;
    wr(8'h30, 32'h44332211, 4'hF, r, er);
    wr(8'h34, 32'h0000_6655, 4'hF, r, er);
    wr(8'h38, 32'h3, 4'hF, r, er);
    vectors++;
    if (r !== 2'b00) begin miscompares++; $display("FAIL commit_bresp: got %b required 00", r); end
    vectors++;
    if (mac_out[96 +: 48] !== 48'h665544332211 || mac_upd_req[2] !== 1'b1 || mac_en[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL commit_out: mac=%h req=%b en=%b required 665544332211/1/1", mac_out[96 +: 48], mac_upd_req[2], mac_en[2]);
    end
    rd(8'h3C, d, r, ed, er);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL commit_status_pending: got %h required 1", d); end
    pulse_ack(2);
    vectors++;
    if (mac_upd_req !== exp_req()) begin miscompares++; $display("FAIL commit_ack_req: got %b required %b", mac_upd_req, exp_req()); end
    rd(8'h3C, d, r, ed, er);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL commit_status_idle: got %h required 0", d); end
  endtask

  task automatic test_overrun();
    logic [31:0] d, ed; logic [1:0] r, er;
    wr(8'h18, 32'h2, 4'hF, r, er);
    wr(8'h10, 32'h12345678, 4'hF, r, er);
    wr(8'h18, 32'h2, 4'hF, r, er);
    vectors++;
    if (mac_out[0 +: 48] !== DMAC || mac_upd_req[0] !== 1'b1) begin
      miscompares++; $display("FAIL overrun_mac: got %h/%b required %h/1", mac_out[0 +: 48], mac_upd_req[0], DMAC);
    end
    rd(8'h1C, d, r, ed, er);
    vectors++;
    if (d !== 32'h3) begin miscompares++; $display("FAIL overrun_status: got %h required 3", d); end
    wr(8'h1C, 32'h2, 4'hF, r, er);
    rd(8'h1C, d, r, ed, er);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL overrun_w1c: got %h required 1", d); end
    pulse_ack(0);
  endtask

  task automatic test_invalid();
    logic [31:0] d, ed; logic [1:0] r, er;
    wr(8'h20, 32'h0, 4'hF, r, er);
    wr(8'h24, 32'h0100, 4'hF, r, er);
    wr(8'h28, 32'h2, 4'hF, r, er);
    rd(8'h2C, d, r, ed, er);
    vectors++;
    if (d !== 32'h4 || mac_upd_req[1] !== 1'b0 || mac_out[48 +: 48] !== DMAC + 48'd1) begin
      miscompares++; $display("FAIL invalid_mcast: status=%h req=%b mac=%h required 4/0/%h", d, mac_upd_req[1], mac_out[48 +: 48], DMAC + 48'd1);
    end
    wr(8'h2C, 32'h4, 4'hF, r, er);
    wr(8'h24, 32'h0, 4'hF, r, er);
    wr(8'h28, 32'h2, 4'hF, r, er);
    rd(8'h2C, d, r, ed, er);
    vectors++;
    if (d !== 32'h4 || mac_upd_req[1] !== 1'b0) begin
      miscompares++; $display("FAIL invalid_zero: status=%h req=%b required 4/0", d, mac_upd_req[1]);
    end
    wr(8'h20, 32'hFFFFFFFF, 4'b0010, r, er);
    rd(8'h20, d, r, ed, er);
    vectors++;
    if (d !== 32'h0000_FF00) begin miscompares++; $display("FAIL wstrb_lane: got %h required 0000ff00", d); end
  endtask

  task automatic test_decerr();
    logic [31:0] d, ed; logic [1:0] r, er;
    rd(8'hF0, d, r, ed, er);
    vectors++;
    if (r !== 2'b11 || d !== 32'h0) begin miscompares++; $display("FAIL decerr_read: got %b/%h required 11/0", r, d); end
    wr(8'h08, 32'h1, 4'hF, r, er);
    vectors++;
    if (r !== 2'b11) begin miscompares++; $display("FAIL decerr_write: got %b required 11", r); end
    wr(8'h00, 32'hFFFFFFFF, 4'hF, r, er);
    vectors++;
    if (r !== 2'b00) begin miscompares++; $display("FAIL ro_write_resp: got %b required 00", r); end
    rd(8'h00, d, r, ed, er);
    vectors++;
    if (d !== 32'h0002_0000) begin miscompares++; $display("FAIL ro_write_value: got %h required 00020000", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, ed; logic [1:0] r, er, wresp, wer;
    model_read(8'h4C, ed, er);
    fork
      axi_write(8'h48, 32'h3, 4'hF, 1'b0, wresp);
      axi_read(8'h4C, d, r);
    join
    model_write(8'h48, 32'h3, 4'hF, wer);
    vectors++;
    if (d !== ed || d[0] !== 1'b0) begin miscompares++; $display("FAIL b2b_status_precommit: got %h required %h", d, ed); end
    vectors++;
    if (mac_upd_req !== exp_req() || mac_out !== exp_mac()) begin
      miscompares++; $display("FAIL b2b_commit: req=%b mac=%h required %b/%h", mac_upd_req, mac_out, exp_req(), exp_mac());
    end
    pulse_ack(3);
  endtask

  task automatic test_random();
    logic [31:0] d, ed, data; logic [1:0] r, er; logic [7:0] addr; int op;
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        addr = 8'($urandom_range(0, 23) * 4);
        data = $urandom;
        wr(addr, data, 4'($urandom_range(0, 15)), r, er);
        vectors++;
        if (r !== er) begin miscompares++; $display("FAIL rand_bresp[%0d] addr=%h: got %b required %b", i, addr, r, er); end
      end else if (op <= 7) begin
        addr = 8'($urandom_range(0, 23) * 4);
        rd(addr, d, r, ed, er);
        vectors++;
        if ({r, d} !== {er, ed}) begin miscompares++; $display("FAIL rand_read[%0d] addr=%h: got %b/%h required %b/%h", i, addr, r, d, er, ed); end
      end else begin
        pulse_ack($urandom_range(0, N - 1));
      end
      vectors++;
      if (mac_out !== exp_mac() || mac_en !== exp_en() || mac_upd_req !== exp_req()) begin
        miscompares++;
        $display("FAIL rand_outputs[%0d]: mac=%h en=%b req=%b required %h/%b/%b", i, mac_out, mac_en, mac_upd_req, exp_mac(), exp_en(), exp_req());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, ed; logic [1:0] r, er;
    if (!m_pend[1]) begin
      wr(8'h24, 32'h0, 4'hF, r, er);
      wr(8'h20, 32'h1, 4'hF, r, er);
      wr(8'h28, 32'h3, 4'hF, r, er);
    end
    vectors++;
    if (mac_upd_req[1] !== 1'b1) begin miscompares++; $display("FAIL mid_req_before: got %b required 1", mac_upd_req[1]); end
    axi_write(8'h00, 32'h0, 4'hF, 1'b1, r);
    vectors++;
    if (S_AXI_BVALID !== 1'b1) begin miscompares++; $display("FAIL mid_bvalid_held: got %b required 1", S_AXI_BVALID); end
    ARESET = 1;
    @(posedge ACLK); #1;
    model_reset();
    vectors++;
    if (S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0 || mac_upd_req !== '0 || mac_en !== '0 || mac_out !== exp_mac()) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: bvalid=%b rvalid=%b req=%b en=%b mac=%h required 0/0/0/0/%h",
               S_AXI_BVALID, S_AXI_RVALID, mac_upd_req, mac_en, mac_out, exp_mac());
    end
    ARESET = 0;
    @(posedge ACLK); #1;
    rd(8'h2C, d, r, ed, er);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL mid_status_cleared: got %h required 0", d); end
  endtask

  initial begin
    ARESET = 1;
    S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    mac_upd_ack = '0;
    test_reset();
    test_commit();
    test_overrun();
    test_invalid();
    test_decerr();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1);
  end

endmodule

// File: doc/mac_addr_table_axil.md
# mac_addr_table_axil

AXI4-Lite register block holding source MAC addresses for `NUM_CH` Ethernet transmit channels. Software writes each channel's address into shadow registers, then commits it atomically. On commit, the block validates the address, copies it to the active output, and runs a req/ack handshake with the channel's datapath. It sits between the PS AXI interconnect and the per-channel frame-header inserters.

## Interface
- `NUM_CH`, 4: number of channels, 1..16
- `ADDR_W`, 8: AXI address width; must be at least log2(0x10 + 0x10·NUM_CH)
- `DEFAULT_MAC`, 48'h000A35000000: reset MAC; channel c resets to `DEFAULT_MAC + c`, a 48-bit add that wraps
- `VERSION`, 32'h0002_0000: value of the VERSION register

Ports:
- `ACLK` in 1: clock
- `ARESET` in 1: reset; synchronous and active-high
- `S_AXI_AW*`: `AWADDR[ADDR_W]`, `AWPROT[3]`, `AWVALID`, `AWREADY`
- `S_AXI_W*`: `WDATA[32]`, `WSTRB[4]`, `WVALID`, `WREADY`
- `S_AXI_B*`: `BRESP[2]`, `BVALID`, `BREADY`
- `S_AXI_AR*`: `ARADDR[ADDR_W]`, `ARPROT[3]`, `ARVALID`, `ARREADY`
- `S_AXI_R*`: `RDATA[32]`, `RRESP[2]`, `RVALID`, `RREADY`
- `mac_out` out `48·NUM_CH`: active MAC per channel; channel c occupies bits [48c+47:48c]
- `mac_en` out `NUM_CH`: channel enable from CTRL.bit0
- `mac_upd_req` out `NUM_CH`: update request, held until acknowledged
- `mac_upd_ack` in `NUM_CH`: datapath acknowledge

## Operation
Address map:
- 0x00 VERSION: read-only.
- 0x04 CH_COUNT: read-only, returns `NUM_CH`.
- Channel c base = 0x10 + 0x10·c. Offsets from the base:
  - +0x0 MAC_LO: shadow MAC[31:0].
  - +0x4 MAC_HI: shadow MAC[47:32] in bits [15:0]; bits [31:16] read 0.
  - +0x8 CTRL: bit0 enable (read/write); bit1 commit (write-1 triggers, always reads 0).
  - +0xC STATUS:
    - bit0 pending: mirrors `mac_upd_req[c]`, read-only.
    - bit1 overrun: sticky, write-1-to-clear.
    - bit2 invalid: sticky, write-1-to-clear.
- Shadow registers reset to the channel's reset MAC.
- Writes honour `WSTRB` per byte.
- Writes to read-only registers are ignored and return OKAY.
- Accesses to unmapped addresses return DECERR (2'b11); reads of unmapped addresses return 0.
- `AWPROT` and `ARPROT` are ignored.

Commit of channel c (CTRL write with bit1 = 1):
- Pending already set: set overrun; active MAC unchanged.
- Otherwise, shadow all-zero or shadow bit40 = 1 (multicast): set invalid; no update.
- Otherwise: copy shadow to `mac_out[c]` and assert `mac_upd_req[c]`.
- Enable bit is written in the same access regardless of the commit outcome.

Per-channel handshake:
- States: IDLE -> REQ on a valid commit; REQ -> IDLE on the cycle `mac_upd_ack[c]` is sampled high.
- Ack in IDLE is ignored.

## Timing
- Reset values: `AWREADY`, `WREADY`, `ARREADY`, `BVALID`, `RVALID` = 0; `BRESP`, `RRESP`, `RDATA` = 0; `mac_out` = reset MACs; `mac_en` = 0; `mac_upd_req` = 0; STATUS = 0.
- Write channel:
  - `AWREADY` and `WREADY` pulse together for one cycle when `AWVALID & WVALID & !BVALID`; AW and W may arrive in either order.
  - The register update occurs on that handshake edge.
  - `BVALID` rises the following cycle and holds until `BREADY`.
- Read channel:
  - `ARREADY` pulses when `ARVALID & !RVALID`.
  - `RVALID` and `RDATA` follow one cycle later and hold until `RREADY`.
- Read and write may complete in the same cycle.
- Commit accepted at edge T: `mac_out` and `mac_upd_req` change at T+1. STATUS read in the same cycle as that write returns pre-commit state.
- Ack sampled high at edge T with req high: req is low after T. The earliest next valid commit is at T+1.
- Simultaneous W1C of a sticky bit and an event that sets it in the same cycle: set wins.
- Reset mid-transaction:
  - Drops `BVALID` and `RVALID` with no response.
  - Aborts pending handshakes.
  - Restores reset MACs.

## Structure
- Package `mac_addr_pkg`:
  - register offset constants (`REG_MAC_LO`, `REG_MAC_HI`, `REG_CTRL`, `REG_STATUS`, `CH_BASE`, `CH_STRIDE`);
  - `resp_t` encodings (OKAY, DECERR);
  - typedef `mac_t` = `logic[47:0]`.
- Sub-module `mac_ch_regs`, instantiated `NUM_CH` times, holds one channel's:
  - shadow/active registers,
  - CTRL/STATUS,
  - commit validation,
  - IDLE/REQ handshake.
- Top level holds the AXI4-Lite FSM, address decode and read mux.

## Test plan
- After reset, read 0x00, 0x04 and 0x10/0x14 with `NUM_CH` = 4 -> 0x00020000, 4, 0x35000000, 0x0000000A. `mac_out[1]` = 0x000A35000001.
- Write MAC_LO = 0x44332211 and MAC_HI = 0x6655 to ch2, then CTRL = 0x3 -> `mac_out[2]` = 0x665544332211 and `mac_upd_req[2]` at T+1. STATUS reads 0x1 until ack, then 0x0.
- Commit ch0 twice without ack -> second commit sets STATUS = 0x3 and `mac_out[0]` is unchanged. W1C 0x2 -> STATUS = 0x1.
- Commit with shadow 0x010000000000 (multicast), then with all-zero -> STATUS.invalid set, no req. Write `WSTRB` = 4'b0010 with `WDATA` 0xFFFFFFFF to MAC_LO -> only bits [15:8] change.
- Read 0xF0 and write 0x08 -> `RRESP`/`BRESP` = DECERR and `RDATA` = 0. Write VERSION -> OKAY and the value is unchanged.
- Assert `ARESET` while `BVALID` is held (`BREADY` = 0) and `mac_upd_req` is high -> all outputs return to reset values the next cycle.
